// File: rtl/uart_prot_trig_if.sv
// Signal bundle between the UART protocol trigger and the capture path that configures it
// and consumes its frame/trigger pulses.
interface uart_prot_trig_if #(
   parameter int DATA_W = 8
);
   // frame_vld is a valid-only strobe with no ready: it is high for exactly one clk and the
   // consumer must take frame_data/err/trig in that cycle; trig and err only assert with it.
   logic              rx;
   logic [15:0]       baud_cnt;
   logic [DATA_W-1:0] match;
   logic [DATA_W-1:0] mask;
   logic              par_en;
   logic              par_odd;
   logic [3:0]        seq_len;
   logic              frame_vld;
   logic [DATA_W-1:0] frame_data;
   logic              err;
   logic              trig;
   logic [2:0]        dbg_state;

   modport master (
      output rx, baud_cnt, match, mask, par_en, par_odd, seq_len,
      input  frame_vld, frame_data, err, trig, dbg_state
   );

   modport slave (
      input  rx, baud_cnt, match, mask, par_en, par_odd, seq_len,
      output frame_vld, frame_data, err, trig, dbg_state
   );
endinterface

// File: rtl/uart_prot_trig.sv
// UART frame decoder that pulses trig once seq_len consecutive good frames match a masked
// pattern; supports 5..16 data bits, optional parity and an idle timeout between frames.
module uart_prot_trig #(
   parameter int DATA_W    = 8,
   parameter int SEQ_DEPTH = 4,
   parameter int IDLE_TO   = 0
) (
   input logic             clk,
   input logic             rst,
   uart_prot_trig_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   localparam logic [4:0]  BIT_LAST  = 5'(DATA_W - 1);
   localparam logic [3:0]  DEPTH     = 4'(SEQ_DEPTH);
   localparam logic [15:0] IDLE_LAST = 16'(IDLE_TO - 1);

   state_t            state, state_nxt;
   logic              s1, s2, s3;
   logic              line, start_edge;
   logic [15:0]       bc, baud_tmr;
   logic [4:0]        bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bad;
   logic [3:0]        seq_cnt, eff_len;
   logic [15:0]       idle_sub, idle_bits;
   logic              tick, stop_bad, hit, seq_done, frame_done, idle_run, idle_expire;
   logic              frame_vld_r, err_r, trig_r;
   logic [DATA_W-1:0] frame_data_r;

   assign line       = s2;
   assign start_edge = s3 & ~s2;
   assign bc         = (bus.baud_cnt < 16'd4) ? 16'd4 : bus.baud_cnt;
   assign tick       = (baud_tmr == 16'd0);
   assign stop_bad   = ~line | par_bad;
   assign hit        = ~stop_bad && (((shreg ^ bus.match) & ~bus.mask) == '0);
   assign seq_done   = ({1'b0, seq_cnt} + 5'd1) >= {1'b0, eff_len};
   assign frame_done = (state == S_STOP) && tick;

   // Bit times spent idle between frames only matter while a sequence is partly matched.
   assign idle_run    = (IDLE_TO != 0) && (state == S_IDLE) && (seq_cnt != 4'd0) && !start_edge;
   assign idle_expire = idle_run && (idle_sub == bc - 16'd1) && (idle_bits == IDLE_LAST);

   always_comb begin
      eff_len = bus.seq_len;
      if (bus.seq_len == 4'd0)
         eff_len = 4'd1;
      else if (bus.seq_len > DEPTH)
         eff_len = DEPTH;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_edge) state_nxt = S_START;
         S_START: if (tick) state_nxt = line ? S_IDLE : S_DATA;
         S_DATA:  if (tick && bit_cnt == BIT_LAST) state_nxt = bus.par_en ? S_PAR : S_STOP;
         S_PAR:   if (tick) state_nxt = S_STOP;
         S_STOP:  if (tick) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         s1           <= 1'b1;
         s2           <= 1'b1;
         s3           <= 1'b1;
         baud_tmr     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_bad      <= 1'b0;
         seq_cnt      <= '0;
         idle_sub     <= '0;
         idle_bits    <= '0;
         frame_vld_r  <= 1'b0;
         err_r        <= 1'b0;
         trig_r       <= 1'b0;
         frame_data_r <= '0;
      end else begin
         s1          <= bus.rx;
         s2          <= s1;
         s3          <= s2;
         state       <= state_nxt;
         frame_vld_r <= 1'b0;
         err_r       <= 1'b0;
         trig_r      <= 1'b0;

         if (state == S_IDLE) begin
            if (start_edge) begin
               baud_tmr <= bc >> 1;
               bit_cnt  <= '0;
               par_bad  <= 1'b0;
            end
         end else if (tick) begin
            // Reload bc-1 so that sampling at zero repeats exactly every bc clocks.
            baud_tmr <= bc - 16'd1;
            if (state == S_DATA) begin
               shreg   <= {line, shreg[DATA_W-1:1]};
               bit_cnt <= bit_cnt + 5'd1;
            end
            if (state == S_PAR)
               par_bad <= (((^shreg) ^ line) != bus.par_odd);
         end else begin
            baud_tmr <= baud_tmr - 16'd1;
         end

         if (frame_done) begin
            frame_vld_r  <= 1'b1;
            frame_data_r <= shreg;
            err_r        <= stop_bad;
            if (hit && seq_done) begin
               trig_r  <= 1'b1;
               seq_cnt <= '0;
            end else if (hit) begin
               seq_cnt <= seq_cnt + 4'd1;
            end else begin
               seq_cnt <= '0;
            end
         end else if (idle_expire) begin
            seq_cnt <= '0;
         end

         if (!idle_run) begin
            idle_sub  <= '0;
            idle_bits <= '0;
         end else if (idle_sub == bc - 16'd1) begin
            idle_sub  <= '0;
            idle_bits <= idle_bits + 16'd1;
         end else begin
            idle_sub <= idle_sub + 16'd1;
         end
      end
   end

   assign bus.frame_vld  = frame_vld_r;
   assign bus.frame_data = frame_data_r;
   assign bus.err        = err_r;
   assign bus.trig       = trig_r;
   assign bus.dbg_state  = state;
endmodule

// File: tb/tb_uart_prot_trig.sv
// Directed bench for uart_prot_trig: an 8-bit instance without idle timeout and a 12-bit
// instance with IDLE_TO=2, each checked by its own scoreboard monitor.
module tb_uart_prot_trig;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   bit_clks = 16;

   // Expected entry: {trig, err, data[15:0]}
   logic [17:0] exp_a_q[$];
   logic [17:0] exp_b_q[$];

   uart_prot_trig_if #(.DATA_W(8))  bus_a ();
   uart_prot_trig_if #(.DATA_W(12)) bus_b ();

   uart_prot_trig #(.DATA_W(8), .SEQ_DEPTH(4), .IDLE_TO(0)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   uart_prot_trig #(.DATA_W(12), .SEQ_DEPTH(4), .IDLE_TO(2)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_a.frame_vld) begin
            if (exp_a_q.size() == 0) begin
               check("a_unexpected_frame", {16'd0, 8'd0, bus_a.frame_data}, 32'hFFFF_FFFF);
            end else begin
               logic [17:0] e;
               e = exp_a_q.pop_front();
               check("a_data", {24'd0, bus_a.frame_data}, {16'd0, e[15:0]});
               check("a_err",  {31'd0, bus_a.err},  {31'd0, e[16]});
               check("a_trig", {31'd0, bus_a.trig}, {31'd0, e[17]});
            end
         end else if (bus_a.trig || bus_a.err) begin
            check("a_pulse_without_vld", {30'd0, bus_a.trig, bus_a.err}, 32'd0);
         end
         if (bus_b.frame_vld) begin
            if (exp_b_q.size() == 0) begin
               check("b_unexpected_frame", {20'd0, bus_b.frame_data}, 32'hFFFF_FFFF);
            end else begin
               logic [17:0] e;
               e = exp_b_q.pop_front();
               check("b_data", {20'd0, bus_b.frame_data}, {16'd0, e[15:0]});
               check("b_err",  {31'd0, bus_b.err},  {31'd0, e[16]});
               check("b_trig", {31'd0, bus_b.trig}, {31'd0, e[17]});
            end
         end else if (bus_b.trig || bus_b.err) begin
            check("b_pulse_without_vld", {30'd0, bus_b.trig, bus_b.err}, 32'd0);
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_rx(input int sel, input logic v);
      if (sel == 0) bus_a.rx = v;
      else          bus_b.rx = v;
   endtask

   task automatic expect_frame(input int sel, input logic [15:0] d, input logic e, input logic t);
      if (sel == 0) exp_a_q.push_back({t, e, d});
      else          exp_b_q.push_back({t, e, d});
   endtask

   task automatic send_frame(input int sel, input int nbits, input logic [15:0] d,
                             input logic par_on, input logic par_bit, input logic stop_bit);
      set_rx(sel, 1'b0);
      hold(bit_clks);
      for (int i = 0; i < nbits; i++) begin
         set_rx(sel, d[i]);
         hold(bit_clks);
      end
      if (par_on) begin
         set_rx(sel, par_bit);
         hold(bit_clks);
      end
      set_rx(sel, stop_bit);
      hold(bit_clks);
      set_rx(sel, 1'b1);
      hold(2);
   endtask

   task automatic cfg_a(input logic [7:0] m, input logic [7:0] mk, input logic [3:0] sl,
                        input logic pe, input logic po);
      bus_a.match = m; bus_a.mask = mk; bus_a.seq_len = sl;
      bus_a.par_en = pe; bus_a.par_odd = po;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_a_vld"},   {31'd0, bus_a.frame_vld},  32'd0);
      check({tag, "_a_err"},   {31'd0, bus_a.err},        32'd0);
      check({tag, "_a_trig"},  {31'd0, bus_a.trig},       32'd0);
      check({tag, "_a_data"},  {24'd0, bus_a.frame_data}, 32'd0);
      check({tag, "_a_state"}, {29'd0, bus_a.dbg_state},  32'd0);
   endtask

   initial begin
      bus_a.rx = 1'b1; bus_a.baud_cnt = 16'd16;
      cfg_a(8'h96, 8'h00, 4'd1, 1'b0, 1'b0);
      bus_b.rx = 1'b1; bus_b.baud_cnt = 16'd16;
      bus_b.match = 12'hA5C; bus_b.mask = 12'h000; bus_b.seq_len = 4'd1;
      bus_b.par_en = 1'b0; bus_b.par_odd = 1'b0;
      hold(4);
      check_reset_outputs("reset");
      check("reset_b_state", {29'd0, bus_b.dbg_state}, 32'd0);
      rst = 1'b0;
      hold(4);

      // Plain 8N1 exact match
      expect_frame(0, 16'h96, 1'b0, 1'b1); send_frame(0, 8, 16'h96, 1'b0, 1'b0, 1'b1);
      // Masked low nibble
      cfg_a(8'h90, 8'h0F, 4'd1, 1'b0, 1'b0);
      expect_frame(0, 16'h9A, 1'b0, 1'b1); send_frame(0, 8, 16'h9A, 1'b0, 1'b0, 1'b1);
      expect_frame(0, 16'hA0, 1'b0, 1'b0); send_frame(0, 8, 16'hA0, 1'b0, 1'b0, 1'b1);
      // Odd parity: 0x96 has four ones, so the correct parity bit is 1
      cfg_a(8'h96, 8'h00, 4'd1, 1'b1, 1'b1);
      expect_frame(0, 16'h96, 1'b1, 1'b0); send_frame(0, 8, 16'h96, 1'b1, 1'b0, 1'b1);
      expect_frame(0, 16'h96, 1'b0, 1'b1); send_frame(0, 8, 16'h96, 1'b1, 1'b1, 1'b1);
      cfg_a(8'h96, 8'h00, 4'd1, 1'b1, 1'b0);
      expect_frame(0, 16'h96, 1'b0, 1'b1); send_frame(0, 8, 16'h96, 1'b1, 1'b0, 1'b1);
      // Two-frame sequences
      cfg_a(8'h55, 8'h00, 4'd2, 1'b0, 1'b0);
      expect_frame(0, 16'h55, 1'b0, 1'b0); send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b1);
      expect_frame(0, 16'h55, 1'b0, 1'b1); send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b1);
      expect_frame(0, 16'h55, 1'b0, 1'b0); send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b1);
      expect_frame(0, 16'h12, 1'b0, 1'b0); send_frame(0, 8, 16'h12, 1'b0, 1'b0, 1'b1);
      expect_frame(0, 16'h55, 1'b0, 1'b0); send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b1);
      expect_frame(0, 16'h55, 1'b1, 1'b0); send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b0);
      hold(bit_clks);
      expect_frame(0, 16'h55, 1'b0, 1'b0); send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b1);
      expect_frame(0, 16'h55, 1'b0, 1'b1); send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b1);
      // seq_len 0 acts as 1; seq_len 15 clamps to four frames
      cfg_a(8'h55, 8'h00, 4'd0, 1'b0, 1'b0);
      expect_frame(0, 16'h55, 1'b0, 1'b1); send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b1);
      cfg_a(8'h55, 8'h00, 4'd15, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         expect_frame(0, 16'h55, 1'b0, (i == 3));
         send_frame(0, 8, 16'h55, 1'b0, 1'b0, 1'b1);
      end
      // False start: 3 clk low glitch
      set_rx(0, 1'b0); hold(3); set_rx(0, 1'b1); hold(3 * bit_clks);
      check("false_start_state", {29'd0, bus_a.dbg_state}, 32'd0);
      // baud_cnt below 4 runs at 4 clocks per bit
      bus_a.baud_cnt = 16'd2; bit_clks = 4;
      cfg_a(8'hC3, 8'h00, 4'd1, 1'b0, 1'b0);
      expect_frame(0, 16'hC3, 1'b0, 1'b1); send_frame(0, 8, 16'hC3, 1'b0, 1'b0, 1'b1);
      bus_a.baud_cnt = 16'd16; bit_clks = 16;
      hold(8);

      // Reset in the middle of data bit 4, then a clean frame
      cfg_a(8'h3C, 8'h00, 4'd1, 1'b0, 1'b0);
      set_rx(0, 1'b0); hold(bit_clks);
      for (int i = 0; i < 4; i++) begin
         set_rx(0, ((8'h3C >> i) & 8'h01) != 8'h00); hold(bit_clks);
      end
      set_rx(0, 1'b1); hold(bit_clks / 2);
      rst = 1'b1; hold(1);
      check_reset_outputs("midrst");
      rst = 1'b0;
      hold(3 * bit_clks);
      expect_frame(0, 16'h3C, 1'b0, 1'b1); send_frame(0, 8, 16'h3C, 1'b0, 1'b0, 1'b1);

      // 12-bit build: round trip, then idle timeout between sequence frames
      expect_frame(1, 16'hA5C, 1'b0, 1'b1); send_frame(1, 12, 16'hA5C, 1'b0, 1'b0, 1'b1);
      bus_b.match = 12'h055; bus_b.seq_len = 4'd2;
      expect_frame(1, 16'h055, 1'b0, 1'b0); send_frame(1, 12, 16'h055, 1'b0, 1'b0, 1'b1);
      hold(3 * bit_clks);
      expect_frame(1, 16'h055, 1'b0, 1'b0); send_frame(1, 12, 16'h055, 1'b0, 1'b0, 1'b1);
      expect_frame(1, 16'h055, 1'b0, 1'b1); send_frame(1, 12, 16'h055, 1'b0, 1'b0, 1'b1);

      hold(4 * bit_clks);
      check("a_frames_outstanding", exp_a_q.size(), 32'd0);
      check("b_frames_outstanding", exp_b_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
